dm_arbiter: RTL and testbench

- Two-master arbiter and access sequencer in front of the single-port word data memory.
- Master 0 is the CPU MEM stage; master 1 is the DMA/loader port.
- Accepts one request at a time, round-robin (or fixed-priority) between masters.
- Performs sub-word stores as read-merge-write against the memory's asynchronous read, and returns read data with a registered valid pulse.

---
 rtl/dm_arbiter.sv | 83 ++++++++
 tb/tb_dm_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master round-robin/fixed-priority sequencer for the word data memory,
// doing sub-word stores as read-merge-write and returning pre-write data with a valid pulse.
module dm_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [31:0] AMASK = 32'((64'd1 << (ADDR_W + 2)) - 64'd1) & 32'hFFFF_FFFC;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      r_state;
  logic        r_rr, r_id, r_mwe;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        w_pick1, w_accept, w_we;
  logic [31:0] w_addr, w_wdata;
  logic [3:0]  w_be;
  // r_rr = 1 means master 1 wins a tie
  assign w_pick1  = m1_req & (~m0_req | (!FIXED_PRIO & r_rr));
  assign w_accept = (r_state == IDLE) & (m0_req | m1_req);
  assign w_we     = w_pick1 ? m1_we : m0_we;
  assign w_addr   = w_pick1 ? m1_addr : m0_addr;
  assign w_wdata  = w_pick1 ? m1_wdata : m0_wdata;
  assign w_be     = w_pick1 ? m1_be : m0_be;
  // reset in the access cycle must suppress the write immediately
  assign mem_we   = r_mwe & ~reset;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign mem_wdata[8*i+:8] = r_be[i] ? r_wdata[8*i+:8] : mem_rdata[8*i+:8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rr      <= 1'b0;
      r_mwe     <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_addr  <= '0;
    end else begin
      m0_gnt    <= w_accept & ~w_pick1;
      m1_gnt    <= w_accept & w_pick1;
      m0_rvalid <= (r_state == ACCESS) & ~r_id;
      m1_rvalid <= (r_state == ACCESS) & r_id;
      r_mwe     <= w_accept & w_we & (w_be != 4'b0);
      if (r_state == ACCESS) begin
        r_state <= IDLE;
        if (r_id) m1_rdata <= mem_rdata;
        else m0_rdata <= mem_rdata;
      end else if (w_accept) begin
        r_state  <= ACCESS;
        r_id     <= w_pick1;
        r_rr     <= ~w_pick1;
        mem_addr <= w_addr & AMASK;
        r_wdata  <= w_wdata;
        r_be     <= w_be;
      end
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural word memory.
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        fp_m0_req, fp_m1_req;
  logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_mem_we;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [31:0] pl_d;
  typedef struct {int id; logic [31:0] d;} exp_t;
  exp_t sbq[$];
  int vectors = 0;
  int errors = 0;

  dm_arbiter #(.FIXED_PRIO(1'b0), .ADDR_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dm_arbiter #(.FIXED_PRIO(1'b1), .ADDR_W(16)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(fp_m0_req), .m0_we(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0), .m0_be(4'hF),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(fp_m1_req), .m1_we(1'b0), .m1_addr(32'h4), .m1_wdata(32'h0), .m1_be(4'hF),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
    .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_rdata(32'h0)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic drive(input int m, input logic r, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (m == 0) begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = wd; m0_be = be; end
    else begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = wd; m1_be = be; end
  endtask

  task automatic access(input int m, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] erd, input logic emwe,
                        input logic [31:0] emwd);
    logic got;
    logic [31:0] rd;
    exp_t e;
    sbq.push_back('{m, erd});
    drive(m, 1'b1, we, a, wd, be);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = (m == 0) ? m0_gnt : m1_gnt;
    end
    vectors++;
    if (!got) begin errors++; $display("FAIL gnt_m%0d: no grant within 8 cycles, required a pulse", m); end
    vectors++;
    if ({m1_gnt, m0_gnt} !== (m == 0 ? 2'b01 : 2'b10)) begin
      errors++; $display("FAIL gnt_pair m%0d: got %b required %b", m, {m1_gnt, m0_gnt}, (m == 0 ? 2'b01 : 2'b10));
    end
    vectors++;
    if (mem_we !== emwe) begin errors++; $display("FAIL mem_we a=%h: got %b required %b", a, mem_we, emwe); end
    vectors++;
    if (mem_addr !== (a & 32'h0003_FFFC)) begin
      errors++; $display("FAIL mem_addr: got %h required %h", mem_addr, a & 32'h0003_FFFC);
    end
    if (emwe) begin
      vectors++;
      if (mem_wdata !== emwd) begin errors++; $display("FAIL mem_wdata: got %h required %h", mem_wdata, emwd); end
    end
    drive(m, 1'b0, we, a, wd, be);
    @(posedge clk); #1;
    vectors++;
    if ({m1_rvalid, m0_rvalid} !== (m == 0 ? 2'b01 : 2'b10)) begin
      errors++; $display("FAIL rvalid m%0d: got %b required %b", m, {m1_rvalid, m0_rvalid}, (m == 0 ? 2'b01 : 2'b10));
    end
    e = sbq.pop_front();
    rd = (e.id == 0) ? m0_rdata : m1_rdata;
    vectors++;
    if (rd !== e.d) begin errors++; $display("FAIL rdata m%0d: got %h required %h", e.id, rd, e.d); end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    vectors++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b required 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    vectors++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h required 0/0", m0_rdata, m1_rdata);
    end
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem: got we=%b addr=%h required 0/0", mem_we, mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    poke(8'd4, 32'hDEADBEEF);
    access(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    access(0, 1'b0, 32'hFFFF_0013, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 32'h0);
  endtask

  task automatic test_write();
    poke(8'd8, 32'h0);
    access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b1, 32'h11223344);
    access(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11223344, 1'b0, 32'h0);
    access(1, 1'b1, 32'h20, 32'h0000AB00, 4'b0010, 32'h11223344, 1'b1, 32'h1122AB44);
    vectors++;
    if (m0_rdata !== 32'h11223344) begin errors++; $display("FAIL other_rdata: got %h required 11223344", m0_rdata); end
    vectors++;
    if (mem[8] !== 32'h1122AB44) begin errors++; $display("FAIL merge_word: got %h required 1122ab44", mem[8]); end
  endtask

  task automatic test_be0();
    poke(8'd12, 32'h55AA55AA);
    access(0, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0, 32'h55AA55AA, 1'b0, 32'h0);
    vectors++;
    if (mem[12] !== 32'h55AA55AA) begin errors++; $display("FAIL be0_word: got %h required 55aa55aa", mem[12]); end
  endtask

  task automatic test_round_robin();
    logic got;
    int w;
    exp_t e;
    logic [31:0] rd;
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      sbq.push_back('{k % 2, (k % 2 == 1) ? 32'h1122AB44 : 32'hDEADBEEF});
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(posedge clk); #1;
        got = m0_gnt | m1_gnt;
      end
      w = m1_gnt ? 1 : 0;
      vectors++;
      if (!got || (m0_gnt & m1_gnt) || w != k % 2) begin
        errors++; $display("FAIL rr_order k=%0d: got gnt=%b required m%0d", k, {m1_gnt, m0_gnt}, k % 2);
      end
      if (w == 0) m0_req = 1'b0; else m1_req = 1'b0;
      @(posedge clk); #1;
      e = sbq.pop_front();
      rd = (e.id == 0) ? m0_rdata : m1_rdata;
      vectors++;
      if (rd !== e.d) begin errors++; $display("FAIL rr_rdata k=%0d: got %h required %h", k, rd, e.d); end
      if (w == 0) m0_req = 1'b1; else m1_req = 1'b1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_fixed_prio();
    int g0, g1;
    g0 = 0; g1 = 0;
    fp_m0_req = 1'b1; fp_m1_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      g0 += int'(fp_m0_gnt);
      g1 += int'(fp_m1_gnt);
    end
    fp_m0_req = 1'b0; fp_m1_req = 1'b0;
    vectors++;
    if (g0 != 6 || g1 != 0) begin errors++; $display("FAIL fixed_prio: got m0=%0d m1=%0d required 6/0", g0, g1); end
  endtask

  task automatic test_reset_access();
    logic got;
    do_reset();
    poke(8'd16, 32'hCAFEF00D);
    drive(1, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin @(posedge clk); #1; got = m1_gnt; end
    reset = 1'b1;
    #1;
    vectors++;
    if (!got || mem_we !== 1'b0) begin errors++; $display("FAIL rst_access_we: got gnt=%b we=%b required 1/0", got, mem_we); end
    m1_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid0: got %b required 0", m1_rvalid); end
    @(posedge clk); #1;
    vectors++;
    if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid1: got %b required 0", m1_rvalid); end
    vectors++;
    if (mem[16] !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_word: got %h required cafef00d", mem[16]); end
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin @(posedge clk); #1; got = m0_gnt | m1_gnt; end
    vectors++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin errors++; $display("FAIL rst_pointer: got %b required 01", {m1_gnt, m0_gnt}); end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  initial begin
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    fp_m0_req = 1'b0; fp_m1_req = 1'b0;
    reset = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_be0();
    test_round_robin();
    test_fixed_prio();
    test_reset_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
